// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU bus initiator and its lane-steering helper.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_lane_align.sv
// Combinational byte-lane steering: misalignment check, byteenable/writedata for stores,
// and lane extraction plus zero/sign extension of read data.
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        signed_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    misaligned = 1'b0;
    byteenable = 4'b0000;
    writedata  = 32'h0;
    rdata_ext  = rdata;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata_ext  = {{24{signed_ld & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        misaligned = addr_lo[0];
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        rdata_ext  = {{16{signed_ld & half_sel[15]}}, half_sel};
      end
      SIZE_WORD: begin
        misaligned = |addr_lo;
        byteenable = BE_WORD;
        writedata  = wdata;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_initiator.sv
// Avalon-style bus master for the CPU core: one load/store at a time, lane steering,
// misalignment rejection and a waitrequest timeout.
module mips_cpu_bus_initiator
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [1:0]       size_q;
  logic [1:0]       addr_lo_q;
  logic             signed_q;
  logic             write_q;
  logic [CNT_W-1:0] wait_cnt;

  logic [1:0]  lane_size;
  logic [1:0]  lane_addr;
  logic        lane_mis;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic [31:0] lane_rdata;

  // Steering looks at the live request while idle and at the captured request during the transfer.
  assign lane_size = (state == IDLE) ? req_size       : size_q;
  assign lane_addr = (state == IDLE) ? req_addr[1:0]  : addr_lo_q;

  mips_bus_lane_align u_lane (
    .size       (lane_size),
    .addr_lo    (lane_addr),
    .signed_ld  (signed_q),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .misaligned (lane_mis),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .rdata_ext  (lane_rdata)
  );

  assign req_ready = rst_n && (state == IDLE);

  // NOTE: state and registered outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      addr_lo_q  <= 2'b00;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wait_cnt   <= '0;
      address    <= 32'h0;
      byteenable <= 4'b0000;
      writedata  <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q    <= req_size;
            addr_lo_q <= req_addr[1:0];
            signed_q  <= req_signed;
            write_q   <= req_write;
            if (lane_mis) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else begin
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= lane_be;
              writedata  <= lane_wd;
              read       <= ~req_write;
              write      <= req_write;
              wait_cnt   <= '0;
              state      <= BUS;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? 32'h0 : lane_rdata;
            state      <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
            // This stall edge is the TIMEOUT_CYCLES-th one: abandon the transfer.
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_initiator.sv
// Scoreboard bench for the CPU bus initiator: expected responses are queued at request
// time and compared when resp_valid pulses; bus-side lanes and latency are checked inline.
module tb_mips_cpu_bus_initiator;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'h0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  mips_cpu_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request through the DUT with a responder that stalls for `stalls` edges.
  task automatic do_access(input string tag, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int stalls,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_strobes);
    int          strobes;
    int          cycles;
    logic        held_ok;
    logic [31:0] first_addr;
    logic [3:0]  first_be;
    logic [31:0] first_wd;
    exp_t        e;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; readdata = rd; waitrequest = 1'b1;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    strobes = 0; cycles = 1; held_ok = 1'b1;
    first_addr = 32'h0; first_be = 4'h0; first_wd = 32'h0;
    while (!resp_valid && cycles < 64) begin
      if (read || write) begin
        strobes++;
        if (strobes == 1) begin
          first_addr = address; first_be = byteenable; first_wd = writedata;
        end
        if (address !== first_addr || byteenable !== first_be || writedata !== first_wd ||
            read !== ~wr || write !== wr)
          held_ok = 1'b0;
      end
      waitrequest = (strobes <= stalls);
      @(negedge clk);
      cycles++;
    end
    waitrequest = 1'b0;
    check({tag, "_resp_seen"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_strobes"}, strobes, exp_strobes);
    check({tag, "_latency"}, cycles, (exp_strobes == 0) ? 1 : exp_strobes + 1);
    check({tag, "_strobe_low"}, {30'b0, read, write}, 32'd0);
    if (exp_strobes > 0) begin
      check({tag, "_held"}, {31'b0, held_ok}, 32'd1);
      check({tag, "_address"}, first_addr, {a[31:2], 2'b00});
      check({tag, "_be"}, {28'b0, first_be}, {28'b0, exp_be});
      if (wr) check({tag, "_wdata"}, first_wd, exp_wd);
    end
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check({tag, "_rdata"}, resp_rdata, e.rdata);
        check({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
      end
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int   seen;
    #12;
    check("rst_strobes", {30'b0, read, write}, 32'd0);
    check("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rst_address", address, 32'h0);
    check("rst_be_wd", {byteenable, writedata[27:0]}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    //        tag       wr    size   sg    addr          wdata         readdata      stl  be       wd            rdata         err  strobes
    do_access("lw_stall", 1'b0, 2'b10, 1'b0, 32'hBFC00010, 32'h0,        32'hDEADBEEF, 6,   4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 7);
    do_access("lb_s",     1'b0, 2'b00, 1'b1, 32'hBFC00013, 32'h0,        32'h80FF0011, 0,   4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 1);
    do_access("lbu",      1'b0, 2'b00, 1'b0, 32'hBFC00013, 32'h0,        32'h80FF0011, 2,   4'b1000, 32'h0,        32'h00000080, 1'b0, 3);
    do_access("sh",       1'b1, 2'b01, 1'b0, 32'hBFC00022, 32'h1234ABCD, 32'hFFFFFFFF, 1,   4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 2);
    do_access("lw_mis",   1'b0, 2'b10, 1'b0, 32'hBFC00001, 32'h0,        32'h11111111, 0,   4'b0000, 32'h0,        32'h0,        1'b1, 0);
    do_access("sh_mis",   1'b1, 2'b01, 1'b0, 32'hBFC00003, 32'h55AA55AA, 32'h0,        0,   4'b0000, 32'h0,        32'h0,        1'b1, 0);
    do_access("size11",   1'b0, 2'b11, 1'b0, 32'hBFC00000, 32'h0,        32'h22222222, 0,   4'b0000, 32'h0,        32'h0,        1'b1, 0);
    do_access("lh_hi_s",  1'b0, 2'b01, 1'b1, 32'h00000102, 32'h0,        32'h80017FFF, 0,   4'b1100, 32'h0,        32'hFFFF8001, 1'b0, 1);
    do_access("lh_lo_s",  1'b0, 2'b01, 1'b1, 32'h00000100, 32'h0,        32'h80017FFF, 3,   4'b0011, 32'h0,        32'h00007FFF, 1'b0, 4);
    do_access("sb",       1'b1, 2'b00, 1'b0, 32'h00000201, 32'h000000A5, 32'h0,        0,   4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 1);
    do_access("sw",       1'b1, 2'b10, 1'b0, 32'h00000304, 32'hCAFEF00D, 32'h0,        2,   4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 3);
    do_access("lw_sgn",   1'b0, 2'b10, 1'b1, 32'h00000400, 32'h0,        32'h80000000, 0,   4'b1111, 32'h0,        32'h80000000, 1'b0, 1);
    do_access("timeout",  1'b0, 2'b10, 1'b0, 32'hBFC00050, 32'h0,        32'h33333333, 100, 4'b1111, 32'h0,        32'h0,        1'b1, 8);

    // Reset while a load is stalled on the bus: strobe must vanish at once and no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'hBFC00060; readdata = 32'h44444444; waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstbus_read_high", {31'b0, read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstbus_read_drop", {30'b0, read, write}, 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("rstbus_no_resp", seen, 0);
    rst_n = 1'b1;
    waitrequest = 1'b0;
    do_access("lw_after", 1'b0, 2'b10, 1'b0, 32'hBFC00040, 32'h0, 32'h12345678, 1, 4'b1111, 32'h0, 32'h12345678, 1'b0, 2);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_initiator.md
Name: mips_cpu_bus_initiator

Overview:
- Bus-master side of the CPU's Avalon-style memory interface (address/read/write/waitrequest/byteenable/readdata/writedata).
- Takes one load/store request at a time from the CPU core and steers byte lanes for byte/half/word accesses.
- Holds read/write until the responder drops waitrequest, then returns extended read data or a completion to the core.
- Adds misalignment detection and a waitrequest timeout.

Parameters:
- TIMEOUT_CYCLES, 1024, number of consecutive waitrequest=1 edges before the access is aborted with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  initiator can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word (11 treated as misaligned)
- req_signed  in  1  sign-extend load result (byte/half only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned or timed out
- address  out  32  word-aligned bus address, req_addr with [1:0] forced to 00
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- waitrequest  in  1  responder stall
- byteenable  out  4  lane enables
- writedata  out  32  lane-steered store data
- readdata  in  32  bus read data

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - read, write, resp_valid and resp_err go to 0.
  - address, byteenable, writedata and resp_rdata go to 0.
  - req_ready goes to 1 once rst_n deasserts.
  - Reset during BUS drops read/write immediately; no response is issued.
- State machine: IDLE -> BUS -> RESP -> IDLE.
  - The ERR path goes IDLE -> RESP directly.
- IDLE:
  - A request is accepted on an edge where req_valid=1 and req_ready=1; the request fields are registered.
  - If misaligned, go to RESP with err=1 and no bus activity. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Otherwise register address, byteenable and writedata, set read or write from the next cycle, and go to BUS.
- Lane rules (little-endian, k = addr[1:0]):
  - byte: byteenable = 1<<k; writedata = {4{wdata[7:0]}}.
  - half: byteenable = addr[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}.
  - word: byteenable = 1111; writedata = wdata.
  - read and write are never high together.
- BUS:
  - address, byteenable, writedata and the strobe are held stable.
  - The transfer completes on the first edge where the strobe is high and waitrequest=0; readdata is sampled on that same edge.
  - waitrequest may rise asynchronously after the strobe rises, so it is only ever evaluated at clock edges.
  - On completion: drop the strobe next cycle and go to RESP.
  - Timeout: a counter counts edges with waitrequest=1 and clears on entry to BUS. When the counter equals TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0), drop the strobe and go to RESP with err=1 and rdata=0.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; then go to IDLE.
  - Load data is lane k (byte) or half addr[1] (half), zero- or sign-extended per req_signed.
  - Word loads ignore req_signed.
  - Stores return rdata=0, err=0.
- Latency:
  - Minimum aligned access: accepted at edge 0, strobe high in cycle 1, completion at edge 1 if waitrequest=0, resp_valid in cycle 2, req_ready in cycle 3.
  - Each waitrequest stall edge adds 1 cycle.
  - Misaligned access: resp_valid in the cycle after acceptance.
- req_valid is ignored outside IDLE, with no queueing.

Decomposition:
- Package mips_bus_pkg holds:
  - size enum: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - initiator state enum: IDLE, BUS, RESP
  - BE_WORD=4'b1111 constant
- One natural combinational sub-module, mips_bus_lane_align. It computes the misaligned flag, byteenable and steered writedata, and extracts and extends readdata. The FSM, timeout counter and registers stay in the top.

Test Plan:
- Aligned word load: addr=0xBFC00010, responder returns 0xDEADBEEF after 6 stall edges.
  - Required: address=0xBFC00010 and byteenable=1111 held for 7 strobe cycles.
  - Required: resp_valid pulse with resp_rdata=0xDEADBEEF, err=0.
- Signed byte load: addr=0xBFC00013, readdata=0x80FF0011, signed=1.
  - Required: byteenable=1000, address=0xBFC00010, resp_rdata=0xFFFFFF80.
  - With signed=0: resp_rdata=0x00000080.
- Half store: addr=0xBFC00022, wdata=0x1234ABCD.
  - Required: write=1, byteenable=1100, writedata=0xABCDABCD.
  - Required: resp_valid with rdata=0, err=0.
- Misaligned access: word load at 0xBFC00001, and half store at 0xBFC00003.
  - Required: read/write never assert; resp_valid the cycle after acceptance, err=1.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck at 1.
  - Required: strobe drops after the 8th stall edge; resp_err=1, rdata=0; req_ready returns.
- Reset during BUS: rst_n pulled low while read=1.
  - Required: read=0 immediately with no resp_valid.
  - Required: after release, a new word load completes normally.
